regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with an attached write-pending scoreboard. It supersedes the fixed 2-read/1-write, 64-bit file in the decode/writeback path, and adds:
- configurable read/write port counts;
- same-cycle write-to-read bypass;
- per-register busy bits that issue sets and writeback clears, for hazard detection.

## Interface
Parameters:
- DATA_W, 64, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads.

Ports (port i occupies slice [i*W +: W] of flattened buses):
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- w_ena  in  NUM_WR  per-port write enable.
- w_addr  in  NUM_WR*ADDR_W  write addresses.
- w_data  in  NUM_WR*DATA_W  write data.
- r_ena  in  NUM_RD  per-port read enable.
- r_addr  in  NUM_RD*ADDR_W  read addresses.
- r_data  out  NUM_RD*DATA_W  read data, combinational.
- r_busy  out  NUM_RD  addressed register has a pending write, combinational.
- iss_ena  in  1  issue: mark destination pending.
- iss_addr  in  ADDR_W  issue destination.
- flush  in  1  clear all busy bits; data is untouched.
- busy_cnt  out  ADDR_W+1  registered count of set busy bits.

## Operation
- Storage:
  - 2**ADDR_W entries of DATA_W bits.
  - Entry 0 is hardwired zero: writes to it are dropped, reads return 0, and its busy bit is never set.
- Write:
  - On each rising edge with rst=0, every port with w_ena=1 and w_addr≠0 updates its entry.
  - Several ports targeting the same address in the same cycle: the highest port index wins.
- Read port i:
  - rst=1 or r_ena[i]=0: r_data=0 and r_busy=0.
  - r_addr=0: r_data=0 and r_busy=0.
  - BYPASS=1 and a live write matches r_addr in the current cycle: r_data = the winning write's w_data. r_busy = 0, unless iss_ena=1 with iss_addr=r_addr in the same cycle, in which case r_busy = 1.
  - Otherwise: r_data = stored entry; r_busy = busy[r_addr].
- Scoreboard update each edge, rst=0, in priority order:
  1. flush=1: every busy bit is cleared. Issue and writeback clears are ignored that cycle.
  2. Else, each live write (w_ena, addr≠0) clears busy[w_addr].
  3. Else-after, iss_ena=1 with iss_addr≠0 sets busy[iss_addr]. A set overrides a same-cycle clear of the same bit, because the new producer is younger.
- Writes to non-busy registers are legal; their clear is a no-op.
- Issuing to an already-busy register leaves it busy. There is no producer count: one writeback clears it.
- busy_cnt equals the population count of the busy vector after the update. It is registered, range 0 .. 2**ADDR_W-1.
- Reset:
  - All entries are 0, all busy bits are 0, busy_cnt=0.
  - rst asserted mid-operation discards any same-cycle write, issue, or flush.
  - r_data and r_busy are 0 while rst=1.

## Timing
- Write latency: data is visible through storage on the cycle after the write edge. With BYPASS=1 it is also visible combinationally in the write cycle itself. With BYPASS=0, a same-cycle read returns the old value.
- Issue to r_busy=1 via storage: 1 cycle. Writeback to r_busy=0: same cycle with BYPASS=1, next cycle otherwise.
- busy_cnt lags the busy vector by 0 cycles: both update on the same edge.
- No stalls and no back-pressure; every port is accepted every cycle.

## Test plan
- Reset: load entries 1..31 with nonzero data, assert rst for 1 cycle. Required: all reads return 0, busy_cnt=0.
- x0 protection: write 0xDEAD to addr 0, then iss_ena to addr 0. Required: read addr0 = 0, r_busy=0, busy_cnt=0.
- Bypass: BYPASS=1, write 0x1234 to x5 while reading x5 (old value 0x55). Required: r_data=0x1234 in the same cycle. With BYPASS=0 the same cycle returns 0x55, and 0x1234 appears next cycle.
- Write conflict: NUM_WR=2, port0 writes 0xA and port1 writes 0xB to x7 in the same cycle. Required: x7=0xB afterwards.
- Scoreboard:
  - Issue x3: next cycle r_busy=1, busy_cnt=1.
  - Same-cycle writeback x3 plus issue x3: remains busy, busy_cnt=1.
  - Writeback x3 alone: busy_cnt=0.
- Flush: issue x1, x2, x4 (busy_cnt=3), then flush with a simultaneous iss_ena x9. Required: busy_cnt=0, x9 not busy, stored data unchanged.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read/write ports,
// issue/flush scoreboard controls and the registered busy count.
interface regfile_mp_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    logic [NUM_WR-1:0]        w_ena;
    logic [NUM_WR*ADDR_W-1:0] w_addr;
    logic [NUM_WR*DATA_W-1:0] w_data;
    logic [NUM_RD-1:0]        r_ena;
    logic [NUM_RD*ADDR_W-1:0] r_addr;
    logic [NUM_RD*DATA_W-1:0] r_data;
    logic [NUM_RD-1:0]        r_busy;
    logic                     iss_ena;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output w_ena, w_addr, w_data,
        output r_ena, r_addr,
        output iss_ena, iss_addr, flush,
        input  r_data, r_busy, busy_cnt
    );

    modport slave (
        input  w_ena, w_addr, w_data,
        input  r_ena, r_addr,
        input  iss_ena, iss_addr, flush,
        output r_data, r_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass
// and a per-register write-pending scoreboard.
module regfile_mp #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    logic [NUM_WR-1:0]        wr_live;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;

    always_comb begin
        wr_live = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            wr_live[p] = bus.w_ena[p] &&
                         (bus.w_addr[p*ADDR_W +: ADDR_W] != '0);
        end
    end

    // Ascending port order lets the highest index win a conflict.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_live[p]) begin
                mem_d[bus.w_addr[p*ADDR_W +: ADDR_W]] =
                    bus.w_data[p*DATA_W +: DATA_W];
            end
        end
        mem_d[0] = '0;
    end

    // Issue is applied after the clears: the new producer is younger.
    always_comb begin
        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_live[p]) begin
                    busy_d[bus.w_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (bus.iss_ena && bus.iss_addr != '0) begin
                busy_d[bus.iss_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] fwd;
        logic              hit;
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        fwd     = '0;
        hit     = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra  = bus.r_addr[i*ADDR_W +: ADDR_W];
            hit = 1'b0;
            fwd = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_live[p] &&
                    bus.w_addr[p*ADDR_W +: ADDR_W] == ra) begin
                    hit = 1'b1;
                    fwd = bus.w_data[p*DATA_W +: DATA_W];
                end
            end
            if (!rst && bus.r_ena[i] && ra != '0) begin
                if (BYPASS != 0 && hit) begin
                    rd_data[i*DATA_W +: DATA_W] = fwd;
                    rd_busy[i] = bus.iss_ena && bus.iss_addr == ra;
                end else begin
                    rd_data[i*DATA_W +: DATA_W] = mem_q[ra];
                    rd_busy[i] = busy_q[ra];
                end
            end
        end
    end

    assign bus.r_data   = rd_data;
    assign bus.r_busy   = rd_busy;
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on/off, two write ports)
// driven identically and compared against an array-based model.
module tb_regfile_mp;
    logic clk;
    logic rst;
    logic [1:0]   w_ena;
    logic [9:0]   w_addr;
    logic [127:0] w_data;
    logic [1:0]   r_ena;
    logic [9:0]   r_addr;
    logic         iss_ena;
    logic [4:0]   iss_addr;
    logic         flush;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] m_mem [32];
    logic [31:0] m_busy;
    logic [5:0]  m_cnt;

    regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2),
                    .NUM_WR(2)) ifa ();
    regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2),
                    .NUM_WR(2)) ifb ();

    regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2),
                 .NUM_WR(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2),
                 .NUM_WR(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb));

    assign ifa.w_ena = w_ena;     assign ifb.w_ena = w_ena;
    assign ifa.w_addr = w_addr;   assign ifb.w_addr = w_addr;
    assign ifa.w_data = w_data;   assign ifb.w_data = w_data;
    assign ifa.r_ena = r_ena;     assign ifb.r_ena = r_ena;
    assign ifa.r_addr = r_addr;   assign ifb.r_addr = r_addr;
    assign ifa.iss_ena = iss_ena; assign ifb.iss_ena = iss_ena;
    assign ifa.iss_addr = iss_addr;
    assign ifb.iss_addr = iss_addr;
    assign ifa.flush = flush;     assign ifb.flush = flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; w_ena = '0; w_addr = '0; w_data = '0;
        r_ena = '0; r_addr = '0; iss_ena = 1'b0;
        iss_addr = '0; flush = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a,
                      input logic [63:0] d);
        w_ena[p] = 1'b1;
        w_addr[p*5 +: 5] = a;
        w_data[p*64 +: 64] = d;
    endtask

    task automatic rd(input int i, input logic [4:0] a);
        r_ena[i] = 1'b1;
        r_addr[i*5 +: 5] = a;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_ena = 1'b1;
        iss_addr = a;
    endtask

    // Expected combinational read for one port, from the model state.
    task automatic exp_read(input int i, input bit byp,
                            output logic [63:0] d, output logic b);
        logic [4:0] a;
        int win;
        a = r_addr[i*5 +: 5];
        d = '0;
        b = 1'b0;
        win = -1;
        for (int p = 0; p < 2; p++)
            if (w_ena[p] && w_addr[p*5 +: 5] == a) win = p;
        if (!rst && r_ena[i] && a != 0) begin
            if (byp && win >= 0) begin
                d = w_data[win*64 +: 64];
                b = iss_ena && iss_addr == a;
            end else begin
                d = m_mem[a];
                b = m_busy[a];
            end
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            for (int k = 0; k < 32; k++) m_mem[k] = '0;
            m_busy = '0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (w_ena[p] && w_addr[p*5 +: 5] != 0)
                    m_mem[w_addr[p*5 +: 5]] = w_data[p*64 +: 64];
            if (flush) begin
                m_busy = '0;
            end else begin
                for (int p = 0; p < 2; p++)
                    if (w_ena[p]) m_busy[w_addr[p*5 +: 5]] = 1'b0;
                if (iss_ena && iss_addr != 0) m_busy[iss_addr] = 1'b1;
            end
            m_busy[0] = 1'b0;
        end
        m_cnt = 6'($countones(m_busy));
    endtask

    task automatic step();
        logic [63:0] ed;
        logic eb;
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_read(i, 1'b1, ed, eb);
            chk("a_rdata", ifa.r_data[i*64 +: 64], ed);
            chk("a_rbusy", 64'(ifa.r_busy[i]), 64'(eb));
            exp_read(i, 1'b0, ed, eb);
            chk("b_rdata", ifb.r_data[i*64 +: 64], ed);
            chk("b_rbusy", 64'(ifb.r_busy[i]), 64'(eb));
        end
        model_commit();
        @(posedge clk);
        #1;
        chk("a_cnt", 64'(ifa.busy_cnt), 64'(m_cnt));
        chk("b_cnt", 64'(ifb.busy_cnt), 64'(m_cnt));
    endtask

    initial begin
        m_busy = '0;
        m_cnt = '0;
        for (int k = 0; k < 32; k++) m_mem[k] = '0;
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_cnt0", 64'(ifa.busy_cnt), 64'd0);

        // Fill every entry, mark many busy, then reset once.
        for (int k = 1; k < 32; k += 2) begin
            idle();
            wr(0, 5'(k), 64'hA5A5_0000_0000_0000 | 64'(k));
            wr(1, 5'(k + 1), 64'h5A5A_0000_0000_0000 | 64'(k + 1));
            iss(5'(k + 2));
            rd(0, 5'(k));
            rd(1, 5'(k - 1));
            step();
        end
        idle();
        rst = 1'b1;
        rd(0, 5'd3);
        step();
        chk("rst_cnt", 64'(ifa.busy_cnt), 64'd0);
        for (int k = 1; k < 32; k += 2) begin
            idle();
            rd(0, 5'(k));
            rd(1, 5'(k + 1));
            #1;
            chk("rst_rd", ifa.r_data[63:0], 64'd0);
            step();
        end

        // x0 is hardwired zero and never busy.
        idle(); wr(0, 5'd0, 64'hDEAD); step();
        idle(); iss(5'd0); step();
        idle(); rd(0, 5'd0);
        #1;
        chk("x0_data", ifa.r_data[63:0], 64'd0);
        chk("x0_busy", 64'(ifa.r_busy[0]), 64'd0);
        chk("x0_cnt", 64'(ifa.busy_cnt), 64'd0);
        step();

        // Bypass on vs off.
        idle(); wr(0, 5'd5, 64'h55); step();
        idle(); wr(0, 5'd5, 64'h1234); rd(0, 5'd5);
        #1;
        chk("byp_on", ifa.r_data[63:0], 64'h1234);
        chk("byp_off", ifb.r_data[63:0], 64'h55);
        step();
        idle(); rd(0, 5'd5);
        #1;
        chk("byp_off_next", ifb.r_data[63:0], 64'h1234);
        step();

        // Two ports to one address: port 1 wins.
        idle(); wr(0, 5'd7, 64'hA); wr(1, 5'd7, 64'hB); rd(0, 5'd7);
        #1;
        chk("conf_byp", ifa.r_data[63:0], 64'hB);
        step();
        idle(); rd(1, 5'd7);
        #1;
        chk("conf_a", ifa.r_data[127:64], 64'hB);
        chk("conf_b", ifb.r_data[127:64], 64'hB);
        step();

        // Scoreboard issue / writeback.
        idle(); iss(5'd3); step();
        chk("sb_iss_cnt", 64'(ifa.busy_cnt), 64'd1);
        idle(); rd(0, 5'd3);
        #1;
        chk("sb_iss_busy", 64'(ifa.r_busy[0]), 64'd1);
        step();
        idle(); wr(0, 5'd3, 64'h33); iss(5'd3); rd(0, 5'd3);
        #1;
        chk("sb_wbiss_a", 64'(ifa.r_busy[0]), 64'd1);
        step();
        chk("sb_wbiss_cnt", 64'(ifa.busy_cnt), 64'd1);
        idle(); wr(1, 5'd3, 64'h34); rd(0, 5'd3);
        #1;
        chk("sb_wb_a", 64'(ifa.r_busy[0]), 64'd0);
        chk("sb_wb_b", 64'(ifb.r_busy[0]), 64'd1);
        step();
        chk("sb_wb_cnt", 64'(ifa.busy_cnt), 64'd0);

        // Flush beats a same-cycle issue; data survives.
        idle(); iss(5'd1); step();
        idle(); iss(5'd2); step();
        idle(); iss(5'd4); step();
        chk("fl_cnt3", 64'(ifa.busy_cnt), 64'd3);
        idle(); flush = 1'b1; iss(5'd9); step();
        chk("fl_cnt0", 64'(ifa.busy_cnt), 64'd0);
        idle(); rd(0, 5'd9); rd(1, 5'd5);
        #1;
        chk("fl_x9", 64'(ifa.r_busy[0]), 64'd0);
        chk("fl_data", ifa.r_data[127:64], 64'h1234);
        step();

        // Random traffic on a narrow address range to force collisions.
        for (int c = 0; c < 400; c++) begin
            idle();
            rst = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < 2; p++) begin
                w_ena[p] = ($urandom_range(0, 2) != 0);
                w_addr[p*5 +: 5] = 5'($urandom_range(0, 9));
                w_data[p*64 +: 64] = {$urandom, $urandom};
                r_ena[p] = ($urandom_range(0, 3) != 0);
                r_addr[p*5 +: 5] = 5'($urandom_range(0, 9));
            end
            iss_ena = $urandom_range(0, 1) != 0;
            iss_addr = 5'($urandom_range(0, 9));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
